// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell reused over WIDTH cycles,
// with a borrow flip-flop and a start/busy/done handshake. D = A - B - Bin mod 2^WIDTH.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             borrow_next;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             load;
    logic             last;

    assign d_bit       = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    assign last        = (cnt == CW'(WIDTH - 1));
    // Newest bit enters at the MSB; the partial register keeps only the WIDTH-1 older bits.
    assign res_next    = {d_bit, res_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            V      <= 1'b0;
        end else if (load) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= Bin;
            cnt    <= '0;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= borrow_next;
            res_sr <= res_next[WIDTH-1:1];
            cnt    <= cnt + CW'(1);
            // Published outputs move only on the final bit so the previous result stays visible.
            if (last) begin
                D    <= res_next;
                Bout <= borrow_next;
                V    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed protocol scenarios plus randomized
// operations at WIDTH=8 and WIDTH=3 against an integer-arithmetic reference.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8, v8;
    logic [7:0] a8, b8, d8;
    logic       start3, bin3, busy3, done3, bout3, v3;
    logic [2:0] a3, b3, d3;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .V(v8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .Bin(bin3),
        .busy(busy3), .done(done3), .D(d3), .Bout(bout3), .V(v3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                    output int d, output int bout, output int v);
        int full, half, sa, sb, sd;
        half = 1 << (w - 1);
        full = a - b - bin;
        bout = (full < 0) ? 1 : 0;
        d    = full & ((1 << w) - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sd   = sa - sb - bin;
        v    = (sd < -half || sd > half - 1) ? 1 : 0;
    endfunction

    task automatic wait8(output int lat, output int bad);
        lat = -1;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
            tick();
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int bad);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait8(lat, bad);
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
        a8 = 8'hA5; b8 = 8'h3C; bin8 = 1'b1; a3 = 3'd5; b3 = 3'd2; bin3 = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy8, done8, d8, bout8, v8} !== 12'h000)
            $display("FAIL reset8: busy/done/D/Bout/V=%h required 000", {busy8, done8, d8, bout8, v8});
        else n_pass++;
        n_checks++;
        if ({busy3, done3, d3, bout3, v3} !== 7'h00)
            $display("FAIL reset3: busy/done/D/Bout/V=%h required 00", {busy3, done3, d3, bout3, v3});
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({busy8, done8, d8, bout8, v8, busy3, done3, d3, bout3, v3} !== 19'h0)
                $display("FAIL idle cycle %0d: outputs=%h required 0", i,
                         {busy8, done8, d8, bout8, v8, busy3, done3, d3, bout3, v3});
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int lat, bad;
        op8(8'd100, 8'd37, 1'b0, lat, bad);
        n_checks++;
        if (lat !== 8) $display("FAIL basic latency: got %0d required 8", lat);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL basic busy: %0d bad cycles required 0", bad);
        else n_pass++;
        n_checks++;
        if ({d8, bout8, v8, busy8} !== {8'd63, 1'b0, 1'b0, 1'b0})
            $display("FAIL basic result: D=%0d Bout=%b V=%b busy=%b required 63 0 0 0", d8, bout8, v8, busy8);
        else n_pass++;
        tick();
        n_checks++;
        if (done8 !== 1'b0 || d8 !== 8'd63)
            $display("FAIL basic pulse: done=%b D=%0d required 0 63", done8, d8);
        else n_pass++;
    endtask

    task automatic test_edges();
        int ta[5] = '{5, 128, 127, 0, 90};
        int tb[5] = '{10, 1, 255, 0, 90};
        int tn[5] = '{0, 0, 0, 1, 0};
        int ed[5] = '{251, 127, 128, 255, 0};
        int eb[5] = '{1, 0, 1, 1, 0};
        int ev[5] = '{0, 1, 1, 0, 0};
        int lat, bad;
        for (int i = 0; i < 5; i++) begin
            op8(8'(ta[i]), 8'(tb[i]), 1'(tn[i]), lat, bad);
            n_checks++;
            if (lat !== 8 || d8 !== 8'(ed[i]) || bout8 !== 1'(eb[i]) || v8 !== 1'(ev[i]))
                $display("FAIL edge %0d: lat=%0d D=%0d Bout=%b V=%b required 8 %0d %0d %0d",
                         i, lat, d8, bout8, v8, ed[i], eb[i], ev[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int lat, bad;
        a8 = 8'd200; b8 = 8'd50; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        tick();
        tick();
        start8 = 1'b0;
        wait8(lat, bad);
        n_checks++;
        if (lat !== 4 || bad !== 0 || d8 !== 8'd150 || bout8 !== 1'b0)
            $display("FAIL ignore_start: lat=%0d bad=%0d D=%0d Bout=%b required 4 0 150 0", lat, bad, d8, bout8);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || d8 !== 8'd150)
                $display("FAIL ignore_start after: done=%b busy=%b D=%0d required 0 0 150", done8, busy8, d8);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bad;
        op8(8'd50, 8'd20, 1'b0, lat, bad);
        n_checks++;
        if (lat !== 8 || d8 !== 8'd30)
            $display("FAIL b2b first: lat=%0d D=%0d required 8 30", lat, d8);
        else n_pass++;
        a8 = 8'd9; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || d8 !== 8'd30)
            $display("FAIL b2b reload: busy=%b done=%b D=%0d required 1 0 30", busy8, done8, d8);
        else n_pass++;
        wait8(lat, bad);
        n_checks++;
        if (lat !== 8 || bad !== 0 || d8 !== 8'd6 || bout8 !== 1'b0)
            $display("FAIL b2b second: lat=%0d bad=%0d D=%0d Bout=%b required 8 0 6 0", lat, bad, d8, bout8);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bad, seen;
        a8 = 8'd77; b8 = 8'd11; bin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, d8, bout8, v8} !== 12'h000)
            $display("FAIL reset_mid: outputs=%h required 000", {busy8, done8, d8, bout8, v8});
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL reset_mid aborted: %0d active cycles required 0", seen);
        else n_pass++;
        op8(8'd20, 8'd1, 1'b0, lat, bad);
        n_checks++;
        if (lat !== 8 || d8 !== 8'd19 || bout8 !== 1'b0)
            $display("FAIL reset_mid next: lat=%0d D=%0d Bout=%b required 8 19 0", lat, d8, bout8);
        else n_pass++;
        tick();
    endtask

    task automatic test_random8();
        int lat, bad, a, b, bin, ed, eb, ev;
        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            bin = int'($urandom_range(0, 1));
            ref_sub(8, a, b, bin, ed, eb, ev);
            op8(8'(a), 8'(b), 1'(bin), lat, bad);
            n_checks++;
            if (lat !== 8 || bad !== 0 || d8 !== 8'(ed) || bout8 !== 1'(eb) || v8 !== 1'(ev))
                $display("FAIL rand8 %0d-%0d-%0d: lat=%0d D=%0d Bout=%b V=%b required 8 %0d %0d %0d",
                         a, b, bin, lat, d8, bout8, v8, ed, eb, ev);
            else n_pass++;
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
    endtask

    task automatic test_random3();
        int lat, a, b, bin, ed, eb, ev;
        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            bin = int'($urandom_range(0, 1));
            ref_sub(3, a, b, bin, ed, eb, ev);
            a3 = 3'(a); b3 = 3'(b); bin3 = 1'(bin); start3 = 1'b1;
            tick();
            start3 = 1'b0;
            a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
            lat = -1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (done3 === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            n_checks++;
            if (lat !== 3 || d3 !== 3'(ed) || bout3 !== 1'(eb) || v3 !== 1'(ev))
                $display("FAIL rand3 %0d-%0d-%0d: lat=%0d D=%0d Bout=%b V=%b required 3 %0d %0d %0d",
                         a, b, bin, lat, d3, bout3, v3, ed, eb, ev);
            else n_pass++;
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first full subtractor for two WIDTH-bit operands.
- One ripple-borrow full-subtractor cell, reused over WIDTH clock cycles with a borrow flip-flop.
- Start/busy/done handshake.
- Inverse-arithmetic companion to the combinational full-adder datapath, for area-constrained paths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; sampled on the edge that accepts start.
- B  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- Bin  input  1  borrow-in; sampled on the edge that accepts start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- D  output  WIDTH  difference, A - B - Bin mod 2^WIDTH.
- Bout  output  1  final borrow; 1 iff A < B + Bin (unsigned).
- V  output  1  signed (two's-complement) overflow of A - B - Bin.

Behaviour:
- Reset: synchronous, active-high, highest priority, effective at any state including mid-operation.
  - State goes to IDLE; the operation is aborted with no done pulse.
  - busy=0, done=0, D=0, Bout=0, V=0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
- FSM states:
  - IDLE (busy=0, done=0)
  - SHIFT (busy=1, done=0)
  - DONE (busy=0, done=1)
- IDLE -> SHIFT on start=1:
  - Load A and B into shift registers, borrow flip-flop <= Bin, counter <= 0.
  - Capture A[WIDTH-1] and B[WIDTH-1] for the overflow calculation.
- SHIFT, each edge:
  - a = A-shift LSB, b = B-shift LSB, br = borrow flip-flop.
  - d = a ^ b ^ br.
  - borrow <= (~a & b) | (~(a ^ b) & br).
  - Shift d into the result register from the MSB side, so that after WIDTH shifts bit i lands at D[i].
  - Shift the A and B registers right by one.
  - counter <= counter + 1.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1).
  - On that edge: D is updated, Bout <= final borrow, V <= (A_msb ^ B_msb) & (A_msb ^ d_msb).
- D, Bout and V change only on that edge or on reset. They hold stable from then until the next accepted start completes.
- Latency: start is sampled on edge 0 and bits are processed on edges 1..WIDTH. done is high for exactly the one cycle after edge WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- DONE -> IDLE if start=0.
- DONE -> SHIFT if start=1 (back-to-back):
  - New operands are loaded as in IDLE.
  - done is still high in that cycle.
  - The previous D/Bout/V remain visible until the new result is written.
- start in SHIFT is ignored: no reload, no effect on the current result, no queueing.
- Operands A, B and Bin may change freely after the accepting edge.
- Counter width is $clog2(WIDTH). No wrap-around beyond WIDTH-1 is possible because the state leaves SHIFT.
- Edge case A=B, Bin=0: D=0, Bout=0, V=0.
- Edge case Bin=1 with A=B: D=all ones, Bout=1.

Test Plan:
- Reset, then idle check: rst=1 for 2 cycles -> busy=0, done=0, D=0, Bout=0, V=0. Idle with start=0 for 20 cycles -> no change.
- WIDTH=8, A=100, B=37, Bin=0, start pulse -> busy high 8 cycles, done in cycle 9 after the accepting edge, D=63, Bout=0, V=0.
- A=5, B=10, Bin=0 -> D=251 (0xFB), Bout=1, V=0. Then A=0x80, B=0x01 -> D=0x7F, Bout=0, V=1. Then A=0x7F, B=0xFF -> D=0x80, Bout=1, V=1.
- A=0, B=0, Bin=1 -> D=0xFF, Bout=1, V=0. Then A=B=0x5A, Bin=0 -> D=0, Bout=0, V=0.
- Protocol:
  - start re-asserted with A=1, B=1 during SHIFT of 200-50 -> ignored; D=150.
  - start during the DONE cycle with A=9, B=3 -> done pulses once per operation, second result D=6, Bout=0, no idle cycle between operations.
  - rst at edge 4 of a SHIFT -> no done pulse, outputs return to 0; the following start with A=20, B=1 -> D=19.
- Randomized: 1000 operations with random A, B, Bin at WIDTH=8 and WIDTH=3, each checked against the reference model {Bout, D} = {1'b0, A} - B - Bin.
